// File: rtl/uart_tx_ctrl_if.sv
// Transmit controller bus: THR write port from the register block, status
// returned to LSR/interrupt logic, and the load/finish handshake with the shifter.
interface uart_tx_ctrl_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             thr_wr_in;
  logic [7:0]       thr_data_in;
  logic             tx_finish_in;
  logic             tx_load_out;
  logic [7:0]       tx_data_out;
  logic             thre_out;
  logic             temt_out;
  logic [LVL_W-1:0] fifo_level_out;
  logic             overflow_out;

  // Register block / shifter side
  modport master (
    output thr_wr_in, thr_data_in, tx_finish_in,
    input  tx_load_out, tx_data_out, thre_out, temt_out, fifo_level_out, overflow_out
  );

  // Transmit controller side
  modport slave (
    input  thr_wr_in, thr_data_in, tx_finish_in,
    output tx_load_out, tx_data_out, thre_out, temt_out, fifo_level_out, overflow_out
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers THR writes in a FIFO (or a single holding
// register when FIFOs are disabled) and hands characters to the shifter one at
// a time, gated by auto-CTS. Produces THRE/TEMT status and an overflow pulse.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_SYNC   = 2
) (
  input  logic           apb_clk_in,
  input  logic           apb_rstn_in,
  input  logic           utrst_in,
  input  logic           fifoen_in,
  input  logic           txclr_in,
  input  logic           afe_in,
  input  logic           cts_in,
  uart_tx_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state_q;
  logic                tx_load_q;
  logic [7:0]          tx_data_q;

  logic [CTS_SYNC-1:0] cts_sync_q;
  logic                fifoen_q;

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_d;
  logic                thre_q;
  logic                ovf_q;

  logic                cts_ok;
  logic                flush;
  logic [LVL_W-1:0]    cap;
  logic                level_nz;
  logic                pop;
  logic                wr_ok;
  logic                push;
  logic                drop;
  logic                start;

  // Bring the asynchronous CTS pin into the clock domain
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      cts_sync_q <= '0;
    end else begin
      cts_sync_q <= {cts_sync_q[CTS_SYNC-2:0], cts_in};
    end
  end

  // Remember the previous FIFO-enable setting so a change can flush the buffer
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      fifoen_q <= 1'b0;
    end else begin
      fifoen_q <= fifoen_in;
    end
  end

  // FIFO control decode: flush beats any write, a pop frees room for a write
  always_comb begin
    cts_ok   = !afe_in || cts_sync_q[CTS_SYNC-1];
    flush    = txclr_in || (fifoen_in != fifoen_q);
    cap      = fifoen_in ? LVL_W'(FIFO_DEPTH) : LVL_W'(1);
    level_nz = (level_q != '0);
    // A load that raced a flush finds the FIFO already empty, so nothing to pop.
    pop      = (state_q == LOAD) && level_nz && !flush;
    wr_ok    = utrst_in && bus.thr_wr_in && !flush;
    push     = wr_ok && ((level_q < cap) || pop);
    drop     = wr_ok && !push;
    start    = level_nz && cts_ok;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // FIFO storage; contents need no reset since level/pointers qualify them
  always_ff @(posedge apb_clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.thr_data_in;
    end
  end

  // FIFO pointers, occupancy, THRE and overflow flag
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      thre_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else if (!utrst_in || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      thre_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
      thre_q  <= (level_d == '0);
      ovf_q   <= drop;
    end
  end

  // Character scheduler: IDLE -> LOAD (one cycle) -> ACTIVE until the shifter finishes
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q   <= IDLE;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else if (!utrst_in) begin
      state_q   <= IDLE;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD;
            tx_load_q <= 1'b1;
            tx_data_q <= mem_q[rd_ptr_q];
          end
        end
        LOAD: begin
          state_q <= ACTIVE;
        end
        ACTIVE: begin
          // CTS is only consulted here; a drop mid-character never aborts it.
          if (bus.tx_finish_in) begin
            if (start) begin
              state_q   <= LOAD;
              tx_load_q <= 1'b1;
              tx_data_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_load_out    = tx_load_q;
  assign bus.tx_data_out    = tx_data_q;
  assign bus.thre_out       = thre_q;
  assign bus.temt_out       = thre_q && (state_q == IDLE);
  assign bus.fifo_level_out = level_q;
  assign bus.overflow_out   = ovf_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed scenarios plus a randomized phase, every
// cycle compared against a queue-based model of the transmit buffer and the
// character hand-off rules.
module tb_uart_tx_ctrl;
  localparam int DEPTH = 16;
  localparam int CS    = 2;

  logic clk = 1'b0;
  logic rstn, utrst, fifoen, txclr, afe, cts;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus();

  uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .CTS_SYNC(CS)) dut (
    .apb_clk_in  (clk),
    .apb_rstn_in (rstn),
    .utrst_in    (utrst),
    .fifoen_in   (fifoen),
    .txclr_in    (txclr),
    .afe_in      (afe),
    .cts_in      (cts),
    .bus         (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0] mq[$];
  bit         ctsq[$];
  bit         m_load, m_active, m_thre, m_ovf, m_fifoen_prev;
  logic [7:0] m_data;

  // Shifter emulation
  int sh_cnt = 0;
  bit hold   = 1'b0;
  bit spur   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ctsq.delete();
    for (int i = 0; i < CS; i++) ctsq.push_back(1'b0);
    m_load = 0; m_active = 0; m_thre = 1; m_ovf = 0; m_data = 8'h00; m_fifoen_prev = 0;
  endtask

  // Predict the state after the coming clock edge from the current inputs.
  task automatic model_step();
    bit sync_now, flush, ok, fin, start_ok, next_active, popped;
    int cap, sz;
    sync_now = ctsq[0];
    cap      = fifoen ? DEPTH : 1;
    flush    = txclr || (fifoen != m_fifoen_prev);
    ok       = !afe || sync_now;
    fin      = bus.tx_finish_in;
    sz       = mq.size();
    m_fifoen_prev = fifoen;
    void'(ctsq.pop_front());
    ctsq.push_back(cts);
    if (!utrst) begin
      mq.delete();
      m_load = 0; m_active = 0; m_thre = 1; m_ovf = 0; m_data = 8'h00;
      return;
    end
    // A new character starts when the shifter is free (or just freed) and data + CTS allow.
    start_ok    = !m_load && (!m_active || fin) && (sz != 0) && ok;
    next_active = m_load || (m_active && !fin);
    if (start_ok) m_data = mq[0];
    m_ovf = 0;
    if (flush) begin
      mq.delete();
    end else begin
      popped = m_load && (sz != 0);
      if (popped) void'(mq.pop_front());
      if (bus.thr_wr_in) begin
        if (sz < cap || popped) mq.push_back(bus.thr_data_in);
        else m_ovf = 1;
      end
    end
    m_load   = start_ok;
    m_active = next_active;
    m_thre   = (mq.size() == 0);
  endtask

  task automatic compare();
    check("load",  bus.tx_load_out,    m_load);
    check("data",  bus.tx_data_out,    m_data);
    check("level", bus.fifo_level_out, mq.size());
    check("thre",  bus.thre_out,       m_thre);
    check("temt",  bus.temt_out,       m_thre && !m_load && !m_active);
    check("ovf",   bus.overflow_out,   m_ovf);
  endtask

  task automatic tick();
    bus.tx_finish_in = 1'b0;
    if (sh_cnt == 1 && !hold) begin
      bus.tx_finish_in = 1'b1;
      sh_cnt = 0;
    end else if (sh_cnt > 1) begin
      sh_cnt--;
    end else if (sh_cnt == 0 && spur && $urandom_range(15) == 0) begin
      bus.tx_finish_in = 1'b1;
    end
    model_step();
    @(posedge clk);
    #1;
    compare();
    if (bus.tx_load_out === 1'b1) sh_cnt = $urandom_range(7, 2);
    bus.thr_wr_in = 1'b0;
    txclr         = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.thr_wr_in   = 1'b1;
    bus.thr_data_in = d;
    tick();
  endtask

  task automatic drain(input int max);
    bit done;
    done = 0;
    for (int i = 0; i < max; i++) begin
      if (mq.size() == 0 && !m_load && !m_active) begin
        done = 1;
        break;
      end
      tick();
    end
    if (mq.size() == 0 && !m_load && !m_active) done = 1;
    check("drain_done", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rstn = 0; utrst = 1; fifoen = 0; txclr = 0; afe = 0; cts = 0;
    bus.thr_wr_in = 0; bus.thr_data_in = 8'h00; bus.tx_finish_in = 0;
    model_reset();
    #12;
    compare();
    @(negedge clk) rstn = 1;
    tick();

    // 1: single-entry mode, A5 loads two cycles after the write
    wr(8'hA5);
    check("t1_level", bus.fifo_level_out, 1);
    tick();
    check("t1_load", bus.tx_load_out, 1);
    check("t1_data", bus.tx_data_out, 8'hA5);
    tick();
    check("t1_thre", bus.thre_out, 1);
    check("t1_temt", bus.temt_out, 0);
    drain(20);
    tick();
    check("t1_temt_end", bus.temt_out, 1);

    // 2: FIFO mode fill to capacity with the shifter stalled, then one dropped write
    fifoen = 1;
    tick();
    hold = 1;
    for (int i = 0; i < 17; i++) wr(8'(i));
    check("t2_peak", bus.fifo_level_out, 16);
    wr(8'h11);
    check("t2_ovf", bus.overflow_out, 1);
    check("t2_level_hold", bus.fifo_level_out, 16);
    tick();
    hold = 0;
    drain(400);

    // 3: auto-CTS holds the character until CTS rises; a later drop does not abort it
    afe = 1; cts = 0;
    wr(8'h3C);
    for (int i = 0; i < 100; i++) tick();
    check("t3_temt_wait", bus.temt_out, 0);
    cts = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus.tx_load_out === 1'b1) got = 1;
    end
    check("t3_load_seen", got, 1);
    check("t3_data", bus.tx_data_out, 8'h3C);
    cts = 0;
    for (int i = 0; i < 20; i++) tick();
    check("t3_temt_done", bus.temt_out, 1);
    afe = 0;

    // 4: clear with a simultaneous write while a character is in flight
    hold = 1;
    for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i));
    check("t4_level5", bus.fifo_level_out, 5);
    bus.thr_wr_in = 1; bus.thr_data_in = 8'hEE; txclr = 1;
    tick();
    check("t4_level0", bus.fifo_level_out, 0);
    check("t4_thre", bus.thre_out, 1);
    check("t4_noovf", bus.overflow_out, 0);
    hold = 0;
    for (int i = 0; i < 20; i++) tick();
    check("t4_idle", bus.temt_out, 1);

    // 5: transmitter reset mid-character, writes ignored while held
    hold = 1;
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
    check("t5_level3", bus.fifo_level_out, 3);
    utrst = 0;
    tick();
    check("t5_level0", bus.fifo_level_out, 0);
    check("t5_temt", bus.temt_out, 1);
    wr(8'h55);
    wr(8'h56);
    check("t5_ignored", bus.fifo_level_out, 0);
    utrst = 1;
    hold  = 0;
    tick();
    wr(8'h7E);
    tick();
    check("t5_load", bus.tx_load_out, 1);
    check("t5_data", bus.tx_data_out, 8'h7E);
    drain(20);

    // 6: asynchronous reset in the middle of a LOAD cycle
    wr(8'h9A);
    tick();
    check("t6_in_load", bus.tx_load_out, 1);
    #2 rstn = 0;
    #1;
    check("t6_rst_load", bus.tx_load_out, 0);
    check("t6_rst_data", bus.tx_data_out, 8'h00);
    check("t6_rst_thre", bus.thre_out, 1);
    check("t6_rst_temt", bus.temt_out, 1);
    check("t6_rst_level", bus.fifo_level_out, 0);
    check("t6_rst_ovf", bus.overflow_out, 0);
    model_reset();
    sh_cnt = 0;
    #2 rstn = 1;
    tick();

    // Randomized traffic
    spur = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2) == 0) begin
        bus.thr_wr_in   = 1'b1;
        bus.thr_data_in = 8'($urandom);
      end
      txclr = ($urandom_range(39) == 0);
      if ($urandom_range(199) == 0) fifoen = ~fifoen;
      if ($urandom_range(99) == 0)  afe = ~afe;
      if ($urandom_range(19) == 0)  cts = ~cts;
      utrst = ($urandom_range(149) != 0);
      tick();
    end
    spur = 0; utrst = 1; afe = 0;
    drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
